// File: rtl/instruction_fetch.sv
// Program-counter and fetch stage of the MiniAlu core: drives the ROM address and registers the word.
// Optional NOP-encoded wait delays are built when NOP_DELAY_EN is defined.
`ifndef NOP
`define NOP 4'h0
`endif

module instruction_fetch #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 28,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [ADDR_WIDTH-1:0]  oROMAddress,
    input  logic [INSTR_WIDTH-1:0] iROMInstruction,
    input  logic                   iStall,
    input  logic                   iBranchTaken,
    input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic                   oInstructionValid,
    output logic [ADDR_WIDTH-1:0]  oPC
);

    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  r_opc;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic                   r_valid;
    logic                   w_delay_hold;

`ifdef NOP_DELAY_EN
    logic [23:0] r_delay_cnt;
    logic        w_is_nop;

    assign w_delay_hold = (r_delay_cnt != 24'd0);
    assign w_is_nop     = (iROMInstruction[INSTR_WIDTH-1 -: 4] == `NOP);

    // Loaded on the same edge that latches the NOP, so the NOP itself is still presented valid.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_delay_cnt <= 24'd0;
        end else if (iBranchTaken) begin
            r_delay_cnt <= 24'd0;
        end else if (w_delay_hold) begin
            if (!iStall) begin
                r_delay_cnt <= r_delay_cnt - 24'd1;
            end
        end else if (!iStall && w_is_nop) begin
            r_delay_cnt <= iROMInstruction[23:0];
        end
    end
`else
    assign w_delay_hold = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_pc    <= RESET_ADDR;
            r_ir    <= '0;
            r_opc   <= '0;
            r_valid <= 1'b0;
        end else if (iBranchTaken) begin
            r_pc    <= iBranchTarget;
            r_ir    <= '0;
            r_valid <= 1'b0;
        end else if (w_delay_hold) begin
            r_valid <= 1'b0;
        end else if (!iStall) begin
            r_ir    <= iROMInstruction;
            r_opc   <= r_pc;
            r_valid <= 1'b1;
            r_pc    <= r_pc + 1'b1;
        end
    end

    assign oROMAddress       = r_pc;
    assign oInstruction      = r_ir;
    assign oInstructionValid = r_valid;
    assign oPC               = r_opc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: table of edge vectors checked through an expectation queue,
// plus hand sequences for reset and (with NOP_DELAY_EN) NOP wait delays.
`ifndef NOP
`define NOP 4'h0
`endif

module tb_instruction_fetch;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        e_valid;
        logic        e_rom;     // 1: oInstruction = rom(e_src) and oPC = e_src; 0: bubble, oInstruction = 0
        logic [15:0] e_src;
        logic [15:0] e_addr;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] oROMAddress;
    logic [27:0] iROMInstruction;
    logic        iStall = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [15:0] iBranchTarget = '0;
    logic [27:0] oInstruction;
    logic        oInstructionValid;
    logic [15:0] oPC;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    localparam logic [15:0] NOP_ADDR = 16'h0100;

    instruction_fetch dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .oROMAddress       (oROMAddress),
        .iROMInstruction   (iROMInstruction),
        .iStall            (iStall),
        .iBranchTaken      (iBranchTaken),
        .iBranchTarget     (iBranchTarget),
        .oInstruction      (oInstruction),
        .oInstructionValid (oInstructionValid),
        .oPC               (oPC)
    );

    always #5 Clock = ~Clock;

    function automatic logic [27:0] rom(input logic [15:0] a);
        if (a == NOP_ADDR) return {`NOP, 24'd3};
        return {4'hA, a[7:0], a};
    endfunction

    assign iROMInstruction = rom(oROMAddress);

    function automatic vec_t mk(input logic s, input logic b, input logic [15:0] t,
                                input logic ev, input logic er, input logic [15:0] es,
                                input logic [15:0] ea);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t;
        v.e_valid = ev; v.e_rom = er; v.e_src = es; v.e_addr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " addr"},  32'(oROMAddress), 32'h0);
        chk({tag, " instr"}, 32'(oInstruction), 32'h0);
        chk({tag, " valid"}, 32'(oInstructionValid), 32'h0);
        chk({tag, " opc"},   32'(oPC), 32'h0);
    endtask

    task automatic step(input string tag, input vec_t v);
        vec_t e;
        iStall        = v.stall;
        iBranchTaken  = v.br;
        iBranchTarget = v.tgt;
        exp_q.push_back(v);
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        chk({tag, " valid"}, 32'(oInstructionValid), 32'(e.e_valid));
        chk({tag, " instr"}, 32'(oInstruction), e.e_rom ? 32'(rom(e.e_src)) : 32'h0);
        if (e.e_rom) chk({tag, " opc"}, 32'(oPC), 32'(e.e_src));
        chk({tag, " addr"}, 32'(oROMAddress), 32'(e.e_addr));
    endtask

    task automatic pulse_reset(input string tag);
        #3 Reset = 1'b0;
        #1 check_reset(tag);
        iStall = 1'b0; iBranchTaken = 1'b0;
        @(posedge Clock);
        #1 check_reset({tag, " held"});
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // fetch A,B; stall 3; C; branch+stall to 5; run; wrap; stall inside bubble
        tbl.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0000, 16'h0001));
        tbl.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0001, 16'h0002));
        tbl.push_back(mk(1, 0, 16'h0,    1, 1, 16'h0001, 16'h0002));
        tbl.push_back(mk(1, 0, 16'h0,    1, 1, 16'h0001, 16'h0002));
        tbl.push_back(mk(1, 0, 16'h0,    1, 1, 16'h0001, 16'h0002));
        tbl.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0002, 16'h0003));
        tbl.push_back(mk(1, 1, 16'h5,    0, 0, 16'h0000, 16'h0005));
        tbl.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0005, 16'h0006));
        tbl.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0006, 16'h0007));
        tbl.push_back(mk(0, 1, 16'hFFFF, 0, 0, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(0, 0, 16'h0,    1, 1, 16'hFFFF, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0000, 16'h0001));
        tbl.push_back(mk(0, 1, 16'h8,    0, 0, 16'h0000, 16'h0008));
        tbl.push_back(mk(1, 0, 16'h0,    0, 0, 16'h0000, 16'h0008));
        tbl.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0008, 16'h0009));
        tbl.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0009, 16'h000A));

        #2 check_reset("reset");
        @(negedge Clock);
        Reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // asynchronous reset while stalled, then restart from RESET_ADDR
        step("stallA", mk(1, 0, 16'h0, 1, 1, 16'h0009, 16'h000A));
        pulse_reset("rst_stall");
        step("restart0", mk(0, 0, 16'h0, 1, 1, 16'h0000, 16'h0001));
        step("restart1", mk(0, 0, 16'h0, 1, 1, 16'h0001, 16'h0002));

        step("nop_br", mk(0, 1, NOP_ADDR, 0, 0, 16'h0, NOP_ADDR));
        step("nop",    mk(0, 0, 16'h0, 1, 1, NOP_ADDR, 16'h0101));
`ifdef NOP_DELAY_EN
        step("dly1", mk(0, 0, 16'h0, 0, 1, NOP_ADDR, 16'h0101));
        step("dly2", mk(0, 0, 16'h0, 0, 1, NOP_ADDR, 16'h0101));
        step("dly3", mk(0, 0, 16'h0, 0, 1, NOP_ADDR, 16'h0101));
        step("dlyX", mk(0, 0, 16'h0, 1, 1, 16'h0101, 16'h0102));

        // one stall inside the delay stretches it to four invalid cycles
        step("s_br",  mk(0, 1, NOP_ADDR, 0, 0, 16'h0, NOP_ADDR));
        step("s_nop", mk(0, 0, 16'h0, 1, 1, NOP_ADDR, 16'h0101));
        step("s_d1",  mk(0, 0, 16'h0, 0, 1, NOP_ADDR, 16'h0101));
        step("s_d2",  mk(1, 0, 16'h0, 0, 1, NOP_ADDR, 16'h0101));
        step("s_d3",  mk(0, 0, 16'h0, 0, 1, NOP_ADDR, 16'h0101));
        step("s_d4",  mk(0, 0, 16'h0, 0, 1, NOP_ADDR, 16'h0101));
        step("s_X",   mk(0, 0, 16'h0, 1, 1, 16'h0101, 16'h0102));

        // branch cancels a pending delay
        step("b_br",  mk(0, 1, NOP_ADDR, 0, 0, 16'h0, NOP_ADDR));
        step("b_nop", mk(0, 0, 16'h0, 1, 1, NOP_ADDR, 16'h0101));
        step("b_d1",  mk(0, 0, 16'h0, 0, 1, NOP_ADDR, 16'h0101));
        step("b_red", mk(0, 1, 16'h0020, 0, 0, 16'h0, 16'h0020));
        step("b_t0",  mk(0, 0, 16'h0, 1, 1, 16'h0020, 16'h0021));
        step("b_t1",  mk(0, 0, 16'h0, 1, 1, 16'h0021, 16'h0022));

        // asynchronous reset mid-delay
        step("r_br",  mk(0, 1, NOP_ADDR, 0, 0, 16'h0, NOP_ADDR));
        step("r_nop", mk(0, 0, 16'h0, 1, 1, NOP_ADDR, 16'h0101));
        step("r_d1",  mk(0, 0, 16'h0, 0, 1, NOP_ADDR, 16'h0101));
        pulse_reset("rst_delay");
        step("r_re0", mk(0, 0, 16'h0, 1, 1, 16'h0000, 16'h0001));
        step("r_re1", mk(0, 0, 16'h0, 1, 1, 16'h0001, 16'h0002));
`else
        step("nop_next",  mk(0, 0, 16'h0, 1, 1, 16'h0101, 16'h0102));
        step("nop_next2", mk(0, 0, 16'h0, 1, 1, 16'h0102, 16'h0103));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and fetch stage of the MiniAlu core. Drives the address of the combinational instruction ROM, registers the returned 28-bit instruction and presents it, with a valid flag and its address, to the decode/execute stage. Handles downstream stalls, branch/jump redirects from execute (with a one-slot flush), and optionally NOP-encoded wait delays.

## Interface
- ADDR_WIDTH, 16, program counter and ROM address width
- INSTR_WIDTH, 28, instruction width: opcode [27:24], destination/immediate fields [23:0]
- RESET_ADDR, 16'd0, PC value after reset

- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- oROMAddress  out  ADDR_WIDTH  address to ROM; equals PC
- iROMInstruction  in  INSTR_WIDTH  ROM data, combinational from oROMAddress
- iStall  in  1  downstream cannot accept; hold fetch state
- iBranchTaken  in  1  execute redirects flow this cycle
- iBranchTarget  in  ADDR_WIDTH  redirect address
- oInstruction  out  INSTR_WIDTH  registered instruction
- oInstructionValid  out  1  oInstruction is a real instruction to execute
- oPC  out  ADDR_WIDTH  address oInstruction was fetched from

## Operation
- Registers: PC, IR (oInstruction), oPC, valid, DelayCnt (24-bit, only with NOP_DELAY_EN).
- oROMAddress = PC, combinational, no extra logic.
- Priority per edge: reset > iBranchTaken > delay hold > iStall > normal fetch.
- Normal fetch (no stall, no branch, DelayCnt=0): IR <= iROMInstruction, oPC <= PC, valid <= 1, PC <= PC+1.
- PC increment wraps modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000), no flag.
- Stall (iStall=1): PC, IR, oPC, valid, DelayCnt all hold.
- Branch (iBranchTaken=1): PC <= iBranchTarget, IR <= 0, valid <= 0, DelayCnt <= 0; overrides iStall and any pending delay. The ROM word at the old PC is discarded (one bubble). Target fetched on the next edge.
- Simultaneous branch and stall: branch wins; the bubble counts as consumed.

## Timing
- Reset (Reset=0, asynchronous): PC=RESET_ADDR, oROMAddress=RESET_ADDR, oInstruction=0, oInstructionValid=0, oPC=0, DelayCnt=0.
- First edge after Reset deasserts: oInstruction=ROM[RESET_ADDR], valid=1, oPC=RESET_ADDR.
- Fetch latency: one cycle from PC to oInstruction; throughput one instruction/cycle when unstalled.
- Branch penalty: exactly one invalid cycle between branch cycle and target instruction.
- Reset mid-delay or mid-stall: all state returns to reset values immediately.

## Configuration
- NOP_DELAY_EN defined: when an instruction with the `NOP opcode (shared definitions header) and nonzero 24-bit field N is latched into IR, it is presented valid for one cycle, then DelayCnt <= N and fetch holds PC for N cycles with valid=0; DelayCnt decrements only on cycles with iStall=0; fetch resumes at PC when DelayCnt reaches 0. N=0 behaves as plain NOP.
- NOP_DELAY_EN undefined: NOP is an ordinary instruction; no DelayCnt register; fetch never self-holds.

## Test plan
- Reset release with ROM[0..3]=A,B,C,D -> oInstruction A,B,C,D on edges 1-4, oPC 0,1,2,3, valid=1 throughout.
- iStall=1 for 3 cycles after B presented -> oInstruction=B, oPC=1, oROMAddress=2 held 3 cycles; C follows on first unstalled edge.
- iBranchTaken=1, iBranchTarget=5 while C presented (same cycle iStall=1) -> next cycle valid=0, oInstruction=0; following cycle oInstruction=ROM[5], oPC=5.
- PC forced to 0xFFFF via branch -> fetch ROM[0xFFFF] then ROM[0x0000], oPC 0xFFFF then 0x0000.
- NOP_DELAY_EN, ROM[0]={`NOP,24'd3}, ROM[1]=X -> NOP valid 1 cycle, valid=0 3 cycles, X valid next; with one iStall cycle inside, 4 invalid cycles; branch during delay -> delay cancelled, target fetched after one bubble.
- Reset asserted asynchronously mid-delay -> all outputs reset values before next edge; restart fetches ROM[RESET_ADDR].
